// File: rtl/fifo_ctrl_syn_pkg.sv
// Shared defaults and types for the synchronous FIFO pointer/flag controller.
package fifo_ctrl_syn_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 3;
    localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;
    localparam int unsigned FIFO_AF_THRESH  = FIFO_DEPTH - 2;
    localparam int unsigned FIFO_AE_THRESH  = 2;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage : fifo_ctrl_syn_pkg

// File: rtl/fifo_ctrl_syn_ptr.sv
// Wrap-bit pointer register: increments modulo 2**PTR_WIDTH, flushes to zero on clr_i.
module fifo_ctrl_syn_ptr #(
    parameter int unsigned PTR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [PTR_WIDTH-1:0] ptr_o
);

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : fifo_ctrl_syn_ptr

// File: rtl/fifo_ctrl_syn.sv
// FIFO pointer and flag controller: gates requests into register-file strobes,
// tracks occupancy and keeps sticky overflow/underflow flags.
module fifo_ctrl_syn
    import fifo_ctrl_syn_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = FIFO_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] AF_T = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_T = AE_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    err_flags_t          err_q;
    err_flags_t          err_d;

    // rst_n gates the strobes so nothing reaches storage while held in reset.
    assign wr_en = wr_req & ~full  & ~clr & rst_n;
    assign rd_en = rd_req & ~empty & ~clr & rst_n;

    fifo_ctrl_syn_ptr #(.PTR_WIDTH(ADDR_WIDTH + 1)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .inc_i (wr_en),
        .ptr_o (wr_ptr)
    );

    fifo_ctrl_syn_ptr #(.PTR_WIDTH(ADDR_WIDTH + 1)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .inc_i (rd_en),
        .ptr_o (rd_ptr)
    );

    assign wr_addr      = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr      = rd_ptr[ADDR_WIDTH-1:0];
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                          (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);

    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = '0;
        end else begin
            if (wr_req && full) begin
                err_d.overflow = 1'b1;
            end
            if (rd_req && empty) begin
                err_d.underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

endmodule : fifo_ctrl_syn

// File: tb/tb_fifo_ctrl_syn.sv
// Self-checking bench for fifo_ctrl_syn: occupancy model plus a data scoreboard
// through a bench-side register file.
module tb_fifo_ctrl_syn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr_req;
    logic       rd_req;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] wr_addr;
    logic [2:0] rd_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    logic [31:0] wdata;
    logic [31:0] mem [8];
    logic [31:0] sb [$];

    int n_tests = 0;
    int n_fail  = 0;

    // Bench model state
    int m_count;
    int m_wa;
    int m_ra;
    int m_ovf;
    int m_unf;

    fifo_ctrl_syn #(
        .ADDR_WIDTH (3),
        .DEPTH      (8),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wa    = 0;
        m_ra    = 0;
        m_ovf   = 0;
        m_unf   = 0;
        sb.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
        chk({tag, ".full"}, 32'(full), 32'(m_count == 8));
        chk({tag, ".afull"}, 32'(almost_full), 32'(m_count >= 6));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_count <= 2));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(m_wa));
        chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(m_ra));
    endtask

    // One clock cycle of stimulus, called and returning at a falling edge.
    task automatic cycle(input string tag, input logic w, input logic r, input logic c);
        int ew;
        int er;
        wr_req = w;
        rd_req = r;
        clr    = c;
        wdata  = $urandom;
        #1;
        ew = (w && m_count < 8 && !c) ? 1 : 0;
        er = (r && m_count > 0 && !c) ? 1 : 0;
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(ew));
        chk({tag, ".rd_en"}, 32'(rd_en), 32'(er));
        if (rd_en === 1'b1) begin
            if (sb.size() == 0) chk({tag, ".rd_unexpected"}, 32'(1), 32'(0));
            else                chk({tag, ".rdata"}, mem[rd_addr], sb.pop_front());
        end
        if (ew == 1) sb.push_back(wdata);
        if (c) begin
            model_reset();
        end else begin
            if (w && m_count == 8) m_ovf = 1;
            if (r && m_count == 0) m_unf = 1;
            if (ew == 1) m_wa = (m_wa + 1) % 8;
            if (er == 1) m_ra = (m_ra + 1) % 8;
            m_count = m_count + ew - er;
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        clr    = 1'b0;
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        wdata  = '0;
        model_reset();

        // 1: reset, strobes held low even with a request pending
        @(negedge clk);
        wr_req = 1'b1;
        #1;
        chk("rst.wr_en", 32'(wr_en), 32'(0));
        wr_req = 1'b0;
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("idle", 1'b0, 1'b0, 1'b0);

        // 2: fill then one write too many
        for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, 1'b0);
        cycle("fill9", 1'b1, 1'b0, 1'b0);

        // 3: drain with data check, then wrap around the address space
        for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("wrap_wr", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("wrap_rd", 1'b0, 1'b1, 1'b0);
        cycle("clr0", 1'b0, 1'b0, 1'b1);

        // 4: simultaneous requests at count 4, full and empty
        for (int i = 0; i < 4; i++) cycle("sim_pre", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("sim4", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("sim_fill", 1'b1, 1'b0, 1'b0);
        cycle("sim_full", 1'b1, 1'b1, 1'b0);
        cycle("sim_clr", 1'b0, 1'b0, 1'b1);
        cycle("sim_empty", 1'b1, 1'b1, 1'b0);
        cycle("sim_rd", 1'b0, 1'b1, 1'b0);

        // 5: clr with a write request at count 5 and overflow set
        cycle("c5_clr", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle("c5_fill", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("c5_rd", 1'b0, 1'b1, 1'b0);
        cycle("c5", 1'b1, 1'b0, 1'b1);

        // 6: asynchronous reset between edges at count 3
        for (int i = 0; i < 3; i++) cycle("ar_fill", 1'b1, 1'b0, 1'b0);
        wr_req = 1'b1;
        rd_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar.wr_en", 32'(wr_en), 32'(0));
        chk("ar.rd_en", 32'(rd_en), 32'(0));
        check_state("ar");
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        check_state("ar_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) cycle("ar_wr", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle("ar_rd", 1'b0, 1'b1, 1'b0);

        // random mixed traffic
        for (int i = 0; i < 60; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_ctrl_syn

// File: doc/fifo_ctrl_syn.md
# fifo_ctrl_syn

Pointer and flag controller for the synchronous FIFO. It sequences the dual-port register file by turning requester `wr_req`/`rd_req` into gated `wr_en`/`rd_en` and `wr_addr`/`rd_addr`. It also maintains occupancy, full/empty/almost flags and sticky overflow/underflow error flags. It sits between the FIFO's client ports and the register-file storage; the FIFO top-level instantiates one of each.

## Interface
Parameters (macros from the shared `parameters.v`):
- `ADDR_WIDTH`, default 3: register-file address width.
- `DEPTH`, default 8: number of entries; must equal 2**`ADDR_WIDTH`.
- `AF_THRESH`, default `DEPTH`-2: `almost_full` asserts when `count` >= `AF_THRESH`.
- `AE_THRESH`, default 2: `almost_empty` asserts when `count` <= `AE_THRESH`.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clr`, input, 1: synchronous flush; empties the FIFO and clears the error flags.
- `wr_req`, input, 1: requester wants to write this cycle.
- `rd_req`, input, 1: requester wants to read this cycle.
- `wr_en`, output, 1: write strobe to the register file.
- `rd_en`, output, 1: read enable to the register file.
- `wr_addr`, output, `ADDR_WIDTH`: register-file write address.
- `rd_addr`, output, `ADDR_WIDTH`: register-file read address.
- `full`, output, 1: `count` == `DEPTH`.
- `empty`, output, 1: `count` == 0.
- `almost_full`, output, 1: `count` >= `AF_THRESH`.
- `almost_empty`, output, 1: `count` <= `AE_THRESH`.
- `count`, output, `ADDR_WIDTH`+1: current occupancy, 0..`DEPTH`.
- `overflow`, output, 1: sticky; set by a `wr_req` while `full`.
- `underflow`, output, 1: sticky; set by an `rd_req` while `empty`.

## Operation
State:
- `wr_ptr`, `rd_ptr`: `ADDR_WIDTH`+1 bits each. The MSB is the wrap bit; the low `ADDR_WIDTH` bits drive `wr_addr`/`rd_addr`.
- `overflow` and `underflow` registers.

Strobe gating and pointer updates:
- `wr_en` = `wr_req` & ~`full` & ~`clr`.
- `rd_en` = `rd_req` & ~`empty` & ~`clr`.
- On each clock edge, `wr_ptr` increments by 1 if `wr_en`, and `rd_ptr` increments by 1 if `rd_en`.
- Pointer increment is modulo 2**(`ADDR_WIDTH`+1). Addresses wrap from `DEPTH`-1 to 0 naturally.

Flag derivation (from registered pointers only; no request input reaches a flag combinationally):
- `count` = `wr_ptr` - `rd_ptr`, computed modulo 2**(`ADDR_WIDTH`+1).
- `empty` = (`wr_ptr` == `rd_ptr`).
- `full` = (MSBs differ) & (low bits equal).

Simultaneous events:
- `wr_en` & `rd_en` both set: both pointers advance and `count` is unchanged.
- Full with `wr_req` & `rd_req`: the read proceeds, the write is dropped, and `overflow` sets. The next cycle shows `count` = `DEPTH`-1.
- Empty with `wr_req` & `rd_req`: the write proceeds, the read is dropped, and `underflow` sets. There is no fall-through of write data.

Error flags:
- `overflow` sets on `wr_req` & `full`.
- `underflow` sets on `rd_req` & `empty`.
- Both hold until `clr` or reset.

`clr`:
- Next edge: both pointers go to 0 and both error flags go to 0.
- The request in the same cycle is ignored, and no error flags are set.

Reset (`rst_n` low, asynchronous, including mid-transfer):
- Pointers go to 0, and `overflow` = `underflow` = 0.
- Resulting outputs: `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `count` = 0, addresses = 0.
- `wr_en` = `rd_en` = 0 while in reset. Storage contents are not cleared.

## Timing
- `wr_en`/`rd_en`/addresses are combinational from the requests and registered state, in the same cycle as the request.
- Register-file read data is valid in the cycle `rd_en` is high (zero-latency read).
- The write lands at the edge ending the `wr_en` cycle. That data is readable from the following cycle at the earliest.
- Flags and `count` update one edge after the causing strobe.
- Error flags are visible one edge after the offending request.
- Reset deassertion: the first strobe is honored at the first rising edge after `rst_n` goes high.

## Structure
- `parameters.v` holds `ADDR_WIDTH`, `DATA_WIDTH`, `DEPTH`, `AF_THRESH` and `AE_THRESH`.
- The controller holds no data path and no sub-modules.
- `fifo_top_syn` instantiates `fifo_ctrl_syn` plus `reg_file_dual_port`, wiring `wr_en`/`rd_en`/`wr_addr`/`rd_addr` directly across.
- Optional: a `fifo_ptr_syn` sub-module (pointer register + increment) instantiated twice. A flat implementation is equally acceptable.

## Test plan
All scenarios use `ADDR_WIDTH`=3, `DEPTH`=8, `AF_THRESH`=6, `AE_THRESH`=2.

1. Reset, then idle: `empty`=1, `almost_empty`=1, `count`=0, `full`=0, `overflow`=`underflow`=0, addresses 0.
2. Fill: 8 consecutive `wr_req` cycles. `wr_addr` steps 0..7; `almost_full` rises after the 6th write; `full`=1 and `count`=8 after the 8th. A 9th `wr_req` gives `wr_en`=0 and `overflow`=1 next cycle, and `count` stays 8.
3. Drain and wrap: after scenario 2, do 8 reads, `rd_addr` 0..7, data intact. Then write 3 and read 3. Addresses wrap to 0..2, `empty`=1 at the end, and the pointer MSBs have toggled.
4. Simultaneous: at `count`=4, assert `wr_req`&`rd_req` for 5 cycles; `count` holds at 4. At `count`=8 with both asserted: the read is accepted, the write is dropped, `count`=7, `overflow`=1. At `count`=0 with both asserted: the write is accepted, `count`=1, `underflow`=1.
5. `clr` with `wr_req` at `count`=5 and `overflow`=1: next cycle `count`=0, `empty`=1, `overflow`=0, and no write has occurred.
6. Async reset mid-burst: drop `rst_n` between edges at `count`=3. All outputs go to their reset values immediately, without waiting for a clock edge; after release, normal writes resume at address 0.
